// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NUM_REQ producers, the write arbiter and the sync_fifo write port.
// The arbiter connects through the slave modport; whoever drives producers and the FIFO flag uses master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*data_width-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_cs;
  logic                          fifo_wr_en;
  logic [data_width-1:0]         fifo_data_in;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_cs, fifo_wr_en, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port between NUM_REQ producers.
// One producer owns the port per grant for at most MAX_BURST words; data passes through with no added latency.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [ID_W-1:0]       owner;
  logic [ID_W-1:0]       last_owner;
  logic [ID_W-1:0]       next_owner;
  logic [CNT_W-1:0]      burst_cnt;
  logic                  busy_q;

  logic                  owner_valid;
  logic                  owner_last;
  logic [data_width-1:0] owner_data;
  logic                  accept;
  logic                  burst_end;
  logic                  release_grant;

  always_comb begin : owner_mux
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == ID_W'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_last  = bus.req_last[i];
        owner_data  = bus.req_data[i*data_width +: data_width];
      end
    end
  end

  // Search starts just past the previous owner so every producer gets a turn.
  always_comb begin : rr_pick
    logic found;
    found      = 1'b0;
    next_owner = last_owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && bus.req_valid[i] && (((int'(last_owner) + k) % NUM_REQ) == i)) begin
          next_owner = ID_W'(i);
          found      = 1'b1;
        end
      end
    end
  end

  assign accept    = (state == GRANT) && owner_valid && !bus.fifo_full;
  assign burst_end = (burst_cnt == CNT_W'(MAX_BURST - 1));

  // A stalled FIFO never ends a grant, even if the owner has gone idle.
  assign release_grant = (state == GRANT) &&
                         ((accept && (owner_last || burst_end)) ||
                          (!owner_valid && !bus.fifo_full));

  always_comb begin : port_drive
    bus.fifo_cs      = 1'b0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_data_in = '0;
    bus.req_ready    = '0;
    if (state == GRANT) begin
      bus.fifo_cs      = 1'b1;
      bus.fifo_wr_en   = accept;
      bus.fifo_data_in = owner_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_ready[i] = accept && (owner == ID_W'(i));
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.grant_id = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            owner     <= next_owner;
            burst_cnt <= '0;
            busy_q    <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_grant) begin
            last_owner <= owner;
            burst_cnt  <= '0;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle table for single-producer and full-stall cases,
// then producer models with a timed scoreboard for rotation, release and reset corners.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DW        = 32;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .data_width(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .data_width(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec_count  = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]   valid;
    logic [3:0]   last;
    logic         full;
    logic [127:0] data;
    logic [3:0]   exp_ready;
    logic         exp_wr;
    logic [31:0]  exp_data;
    logic [1:0]   exp_gid;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int cnt[4], len[4], last_at[4], start[4], gap_lo[4], gap_hi[4];
  int cyc;
  logic [7:0] tag;

  function automatic logic [31:0] word(input int i, input int k);
    return {tag, 8'(i), 16'(k)};
  endfunction

  task automatic add_vec(input logic [3:0] valid, input logic [3:0] last, input logic full,
                         input int src, input logic [31:0] w,
                         input logic [3:0] er, input logic ew, input logic [31:0] ed,
                         input logic [1:0] eg, input logic eb);
    vec_t v;
    v.valid = valid; v.last = last; v.full = full;
    for (int i = 0; i < 4; i++)
      v.data[i*32 +: 32] = (i == src) ? w : (32'hDEAD_0000 + 32'(i));
    v.exp_ready = er; v.exp_wr = ew; v.exp_data = ed; v.exp_gid = eg; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.req_valid = v.valid;
    bus.req_last  = v.last;
    bus.req_data  = v.data;
    bus.fifo_full = v.full;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    #1;
    vec_count++;
    if (bus.req_ready !== v.exp_ready || bus.fifo_wr_en !== v.exp_wr ||
        bus.fifo_data_in !== v.exp_data || bus.grant_id !== v.exp_gid ||
        bus.busy !== v.exp_busy || bus.fifo_cs !== v.exp_busy) begin
      $display("[TB] FAIL vec%0d: got ready=%b wr=%b data=%h gid=%0d busy=%b cs=%b, want ready=%b wr=%b data=%h gid=%0d busy=%b cs=%b",
               idx, bus.req_ready, bus.fifo_wr_en, bus.fifo_data_in, bus.grant_id, bus.busy, bus.fifo_cs,
               v.exp_ready, v.exp_wr, v.exp_data, v.exp_gid, v.exp_busy, v.exp_busy);
      miscompares++;
    end
  endtask

  task automatic checkZero(input string name);
    vec_count++;
    if (bus.req_ready !== 4'b0 || bus.fifo_cs !== 1'b0 || bus.fifo_wr_en !== 1'b0 ||
        bus.fifo_data_in !== 32'b0 || bus.grant_id !== 2'b0 || bus.busy !== 1'b0) begin
      $display("[TB] FAIL %s: got ready=%b cs=%b wr=%b data=%h gid=%0d busy=%b, want all zero",
               name, bus.req_ready, bus.fifo_cs, bus.fifo_wr_en, bus.fifo_data_in, bus.grant_id, bus.busy);
      miscompares++;
    end
  endtask

  task automatic checkDrained(input string name);
    vec_count++;
    if (sb.size() != 0) begin
      $display("[TB] FAIL %s: got %0d writes still outstanding, want 0", name, sb.size());
      miscompares++;
    end
  endtask

  task automatic push_exp(input int id, input int k, input int c);
    exp_t e;
    e.id = id; e.data = word(id, k); e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drive_producers();
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = (cyc >= start[i]) && (cnt[i] < len[i]) &&
                         !((cyc >= gap_lo[i]) && (cyc < gap_hi[i]));
      d[i*32 +: 32]   = word(i, cnt[i]);
      bus.req_last[i]  = (cnt[i] == last_at[i]);
    end
    bus.req_data  = d;
    bus.fifo_full = 1'b0;
  endtask

  // Compares this cycle's write port against the scoreboard head, which carries its due cycle.
  task automatic checkWrite();
    logic exp_wr;
    exp_t e;
    exp_wr = (sb.size() > 0) && (sb[0].cyc == cyc);
    vec_count++;
    if (bus.fifo_wr_en !== exp_wr) begin
      $display("[TB] FAIL wr_en cyc%0d tag%h: got %b want %b", cyc, tag, bus.fifo_wr_en, exp_wr);
      miscompares++;
    end else if (exp_wr) begin
      e = sb.pop_front();
      if (bus.fifo_data_in !== e.data || bus.grant_id !== 2'(e.id) ||
          bus.req_ready !== (4'b1 << e.id) || bus.busy !== 1'b1) begin
        $display("[TB] FAIL write cyc%0d: got data=%h gid=%0d ready=%b busy=%b, want data=%h gid=%0d ready=%b busy=1",
                 cyc, bus.fifo_data_in, bus.grant_id, bus.req_ready, bus.busy,
                 e.data, e.id, 4'b1 << e.id);
        miscompares++;
      end
    end else if (bus.req_ready !== 4'b0) begin
      $display("[TB] FAIL ready cyc%0d: got %b want 0000", cyc, bus.req_ready);
      miscompares++;
    end
  endtask

  task automatic step_body();
    logic [3:0] rdy;
    drive_producers();
    #1;
    checkWrite();
    rdy = bus.req_ready;
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (rdy[i]) cnt[i]++;
    cyc++;
  endtask

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      step_body();
    end
  endtask

  task automatic seq_reset(input logic [7:0] t);
    tag = t;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0; len[i] = 0; last_at[i] = -1; start[i] = 0; gap_lo[i] = -1; gap_hi[i] = -1;
    end
    sb.delete();
    cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200us, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    seq_reset(8'h00);
    rst = 1'b1;
    #1;
    checkZero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Requester 0 alone: 100, 200, 300 with last on 300.
    add_vec(4'b0001, 4'b0000, 1'b0, 0, 32'd100, 4'b0000, 1'b0, 32'd0,   2'd0, 1'b0);
    add_vec(4'b0001, 4'b0000, 1'b0, 0, 32'd100, 4'b0001, 1'b1, 32'd100, 2'd0, 1'b1);
    add_vec(4'b0001, 4'b0000, 1'b0, 0, 32'd200, 4'b0001, 1'b1, 32'd200, 2'd0, 1'b1);
    add_vec(4'b0001, 4'b0001, 1'b0, 0, 32'd300, 4'b0001, 1'b1, 32'd300, 2'd0, 1'b1);
    add_vec(4'b0000, 4'b0000, 1'b0, 0, 32'd0,   4'b0000, 1'b0, 32'd0,   2'd0, 1'b0);
    // Requester 2: two writes, five full cycles, then six more writes ending the burst at 8.
    add_vec(4'b0100, 4'b0000, 1'b0, 2, 32'h2000, 4'b0000, 1'b0, 32'h0,    2'd0, 1'b0);
    add_vec(4'b0100, 4'b0000, 1'b0, 2, 32'h2000, 4'b0100, 1'b1, 32'h2000, 2'd2, 1'b1);
    add_vec(4'b0100, 4'b0000, 1'b0, 2, 32'h2001, 4'b0100, 1'b1, 32'h2001, 2'd2, 1'b1);
    for (int f = 0; f < 5; f++)
      add_vec(4'b0100, 4'b0000, 1'b1, 2, 32'h2002, 4'b0000, 1'b0, 32'h2002, 2'd2, 1'b1);
    for (int k = 2; k < 8; k++)
      add_vec(4'b0100, 4'b0000, 1'b0, 2, 32'h2000 + 32'(k), 4'b0100, 1'b1, 32'h2000 + 32'(k), 2'd2, 1'b1);
    add_vec(4'b0000, 4'b0000, 1'b0, 2, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd2, 1'b0);
    add_vec(4'b0000, 4'b0000, 1'b0, 2, 32'h0, 4'b0000, 1'b0, 32'h0, 2'd2, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // All four streaming, never last: 0,1,2,3,0 with 8 writes each and a bubble between.
    seq_reset(8'h02);
    for (int i = 0; i < 4; i++) len[i] = 100;
    for (int g = 0; g < 5; g++)
      for (int j = 0; j < 8; j++)
        push_exp(g % 4, (g == 4 ? 8 : 0) + j, 9 * g + 1 + j);
    step(45);
    checkDrained("rotation");

    // Requester 1 goes idle after 3 words; 2, 3, 0 are served before it returns.
    seq_reset(8'h04);
    len[1] = 5; last_at[1] = 4; gap_lo[1] = 4; gap_hi[1] = 6;
    len[0] = 2; last_at[0] = 1; start[0] = 2;
    len[2] = 2; last_at[2] = 1; start[2] = 2;
    len[3] = 2; last_at[3] = 1; start[3] = 2;
    for (int k = 0; k < 3; k++) push_exp(1, k, 1 + k);
    push_exp(2, 0, 6);  push_exp(2, 1, 7);
    push_exp(3, 0, 9);  push_exp(3, 1, 10);
    push_exp(0, 0, 12); push_exp(0, 1, 13);
    push_exp(1, 3, 15); push_exp(1, 4, 16);
    step(19);
    checkDrained("idle_release");

    // Last on the 8th word coincides with the burst limit: one release, then one bubble.
    seq_reset(8'h06);
    len[0] = 8; last_at[0] = 7;
    len[1] = 2; last_at[1] = 1;
    for (int k = 0; k < 8; k++) push_exp(0, k, 1 + k);
    push_exp(1, 0, 10); push_exp(1, 1, 11);
    step(14);
    checkDrained("last_at_limit");

    // Reset lands mid-burst on requester 2; the offered word must not be written.
    seq_reset(8'h05);
    len[2] = 6;
    for (int k = 0; k < 3; k++) push_exp(2, k, 1 + k);
    step(4);
    @(negedge clk);
    drive_producers();
    #1;
    rst = 1'b1;
    #1;
    checkZero("reset_async");
    len[0] = 2; last_at[0] = 1;
    drive_producers();
    @(posedge clk);
    #1;
    checkZero("reset_held");
    checkDrained("pre_reset_writes");
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    push_exp(0, 0, 1); push_exp(0, 1, 2);
    push_exp(2, 3, 4); push_exp(2, 4, 5); push_exp(2, 5, 6);
    step_body();
    step(9);
    checkDrained("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule
